blake3_chunk_seq: RTL
=====================

BLAKE3_CHUNK_SEQ -- requirements
Module: blake3_chunk_seq

Interface
REQ-001 Parameter: MAX_LEN, 1024, maximum message length in bytes (one BLAKE3 chunk, 16 blocks).
REQ-002 Clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Rst_n  in  1  asynchronous, active-low reset.
REQ-004 Start_I  in  1  one-cycle request to begin hashing a new message.
REQ-005 MsgLen_I  in  11  message length in bytes, 0..MAX_LEN; sampled when Start_I is accepted.
REQ-006 Word_I  in  32  message word, little-endian (byte 0 in bits 7:0).
REQ-007 WordVld_I  in  1  Word_I is valid.
REQ-008 WordRdy_O  out  1  block accepts Word_I; a word transfers when WordVld_I and WordRdy_O are both high.
REQ-009 HgStrt_O  out  1  one-cycle start pulse to the downstream HashGen compression stage.
REQ-010 HgBL_O  out  32  block length in bytes for the current block.
REQ-011 HgCS_O, HgCE_O, HgRoot_O  out  1 each  CHUNK_START, CHUNK_END and ROOT flags.
REQ-012 HgH_O  out  8x32  input chaining value, word 0 at index 0.
REQ-013 HgMsg_O  out  16x32  message block, word 0 at index 0.
REQ-014 HgVld_I  in  1  compression result valid, one-cycle pulse.
REQ-015 HgH_I  in  8x32  compression result (H0..H7).
REQ-016 Dig_O  out  8x32  final digest.
REQ-017 DigVld_O  out  1  one-cycle pulse; Dig_O is valid.
REQ-018 Busy_O  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, FIRE, WAIT and DONE.
REQ-020 IDLE: when Start_I=1, latch MsgLen_I, set nblk = max(1, ceil(len/64)) and nwords = ceil(len/4), clear block index and word counter, and go to LOAD; if len=0, go directly to FIRE.
REQ-021 Start_I SHALL be ignored in all states other than IDLE.
REQ-022 LOAD: WordRdy_O=1; each accepted word is written into slot (word count mod 16) of the block buffer.
REQ-023 LOAD SHALL go to FIRE on the cycle after the 16th word of the block is accepted, or after the last message word (nwords) is accepted.
REQ-024 Gaps in WordVld_I SHALL stall LOAD with no other effect.
REQ-025 In the final message word, bytes at positions >= len SHALL be forced to zero.
REQ-026 Buffer slots not written in the final block SHALL be zero.
REQ-027 The buffer SHALL be cleared on entry to LOAD and on Start_I acceptance.
REQ-028 FIRE lasts one cycle: HgStrt_O=1, then go to WAIT.
REQ-029 Block flags in FIRE: HgCS_O=1 iff block index = 0; HgCE_O=1 and HgRoot_O=1 iff block index = nblk-1.
REQ-030 Block length in FIRE: HgBL_O = 64 for non-last blocks; for the last block HgBL_O = len - 64*(nblk-1), which is 0 when len=0.
REQ-031 Chaining value in FIRE: HgH_O = IV_0..IV_7 from defines for block 0; otherwise HgH_O = the HgH_I captured from the previous block.
REQ-032 HgBL_O, the three flags, HgH_O and HgMsg_O SHALL be held stable from FIRE until HgVld_I is seen in WAIT.
REQ-033 WAIT: WordRdy_O=0.
REQ-034 WAIT on HgVld_I=1: capture HgH_I into the chaining register; if the block was last, go to DONE, else increment the block index and go to LOAD.
REQ-035 HgVld_I SHALL be ignored outside WAIT.
REQ-036 HgVld_I in the same cycle as HgStrt_O SHALL be ignored (FIRE is not WAIT).
REQ-037 DONE lasts one cycle: Dig_O = captured chaining value, DigVld_O=1, then go to IDLE.
REQ-038 Dig_O SHALL hold its value until the next DONE.
REQ-039 Latency: a single-block message SHALL raise HgStrt_O exactly 1 cycle after the last word transfer.
REQ-040 Latency: DigVld_O SHALL rise exactly 1 cycle after the final HgVld_I.
REQ-041 Counters SHALL be sized so that len=1024 (16 blocks, 256 words) does not wrap; the word counter stops at nwords.

Reset
REQ-042 Rst_n=0 SHALL immediately force IDLE, even mid-LOAD, FIRE or WAIT.
REQ-043 Rst_n=0 SHALL clear WordRdy_O, HgStrt_O, HgCS_O, HgCE_O, HgRoot_O, DigVld_O and Busy_O to 0.
REQ-044 Rst_n=0 SHALL clear HgBL_O, HgH_O, HgMsg_O, Dig_O, the buffer, the counters and the chaining register to 0.
REQ-045 After reset is released, a stale HgVld_I SHALL have no effect.

Verification
REQ-046 len=64, words j*0x55 (j=0..15) -> one HgStrt_O pulse 1 cycle after word 15; BL=64; CS=CE=ROOT=1; HgH_O=IV; HgMsg_O[j]=j*0x55. HgVld_I then gives DigVld_O 1 cycle later with Dig_O=HgH_I.
REQ-047 len=0 -> no word accepted (WordRdy_O stays 0); FIRE with HgMsg_O all zero, BL=0, CS=CE=ROOT=1.
REQ-048 len=65, words 0x11223344 repeated -> block 0: BL=64, CS=1, CE=ROOT=0, H=IV. Block 1: BL=1, CS=0, CE=ROOT=1, H=block-0 HgH_I, HgMsg_O[0]=0x00000044, slots 1..15 zero.
REQ-049 len=1024 with random WordVld_I gaps -> exactly 16 HgStrt_O pulses; only pulse 1 has CS=1; only pulse 16 has CE=ROOT=1; 256 words accepted.
REQ-050 Start_I pulsed during WAIT, and HgVld_I pulsed during LOAD -> both ignored; block count and outputs unchanged.
REQ-051 Rst_n low for 1 cycle during WAIT of block 2 of len=200 -> all outputs 0 and IDLE; a following len=64 message hashes correctly with H=IV.

Source files
------------

// File: rtl/blake3_chunk_seq_if.sv
// blake3_chunk_seq_if: message/HashGen/digest bundle for blake3_chunk_seq
//   start, msg_len            : new-message request and its length in bytes
//   word, word_vld, word_rdy  : little-endian message word stream
//   hg_strt, hg_bl, hg_cs, hg_ce, hg_root, hg_h, hg_msg : compression request
//   hg_vld, hg_res            : compression result
//   dig, dig_vld, busy        : final digest and status
interface blake3_chunk_seq_if;
  logic start;
  logic [10:0] msg_len;
  logic [31:0] word;
  logic word_vld;
  logic word_rdy;
  logic hg_strt;
  logic [31:0] hg_bl;
  logic hg_cs;
  logic hg_ce;
  logic hg_root;
  logic [7:0][31:0] hg_h;
  logic [15:0][31:0] hg_msg;
  logic hg_vld;
  logic [7:0][31:0] hg_res;
  logic [7:0][31:0] dig;
  logic dig_vld;
  logic busy;
  modport slave (
    input start, msg_len, word, word_vld, hg_vld, hg_res,
    output word_rdy, hg_strt, hg_bl, hg_cs, hg_ce, hg_root, hg_h, hg_msg, dig, dig_vld, busy
  );
  modport master (
    output start, msg_len, word, word_vld, hg_vld, hg_res,
    input word_rdy, hg_strt, hg_bl, hg_cs, hg_ce, hg_root, hg_h, hg_msg, dig, dig_vld, busy
  );
endinterface

// File: rtl/blake3_chunk_seq.sv
// blake3_chunk_seq: splits one BLAKE3 chunk (<= MAX_LEN bytes) into 64-byte compression requests
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of blake3_chunk_seq_if (message in, HashGen request/response, digest out)
module blake3_chunk_seq #(
  parameter int MAX_LEN = 1024
) (
  input logic clk,
  input logic rst_n,
  blake3_chunk_seq_if.slave bus
);
  localparam int WCW = $clog2(MAX_LEN / 4 + 1);
  localparam int BCW = $clog2(MAX_LEN / 64 + 1);
  localparam logic [7:0][31:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                     32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} state_t;
  state_t state;
  logic [10:0] len;
  logic [BCW-1:0] nblk, blk;
  logic [WCW-1:0] nwords, wcnt;
  logic [7:0][31:0] cv;
  logic [15:0][31:0] msg;
  logic [10:0] blk_up, wd_up;
  logic [31:0] mask;
  logic last_word, blk_full, last_blk;
  assign bus.hg_msg = msg;
  always_comb begin
    blk_up = bus.msg_len + 11'd63;
    wd_up = bus.msg_len + 11'd3;
    last_word = wcnt == nwords - WCW'(1);
    blk_full = wcnt[3:0] == 4'd15;
    last_blk = blk == nblk - BCW'(1);
    // only the final message word can carry bytes beyond len
    mask = !last_word || len[1:0] == 2'd0 ? 32'hFFFFFFFF :
           len[1:0] == 2'd1 ? 32'h000000FF :
           len[1:0] == 2'd2 ? 32'h0000FFFF : 32'h00FFFFFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      nblk <= '0;
      blk <= '0;
      nwords <= '0;
      wcnt <= '0;
      cv <= '0;
      msg <= '0;
      bus.word_rdy <= 1'b0;
      bus.hg_strt <= 1'b0;
      bus.hg_bl <= '0;
      bus.hg_cs <= 1'b0;
      bus.hg_ce <= 1'b0;
      bus.hg_root <= 1'b0;
      bus.hg_h <= '0;
      bus.dig <= '0;
      bus.dig_vld <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.hg_strt <= 1'b0;
      bus.dig_vld <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          len <= bus.msg_len;
          nblk <= bus.msg_len == '0 ? BCW'(1) : BCW'(blk_up >> 6);
          nwords <= WCW'(wd_up >> 2);
          blk <= '0;
          wcnt <= '0;
          msg <= '0;
          bus.busy <= 1'b1;
          // an empty message is a single all-zero block fired straight away
          if (bus.msg_len == '0) begin
            state <= FIRE;
            bus.hg_strt <= 1'b1;
            bus.hg_bl <= '0;
            bus.hg_cs <= 1'b1;
            bus.hg_ce <= 1'b1;
            bus.hg_root <= 1'b1;
            bus.hg_h <= IV;
          end else begin
            state <= LOAD;
            bus.word_rdy <= 1'b1;
          end
        end
        LOAD: if (bus.word_vld) begin
          msg[wcnt[3:0]] <= bus.word & mask;
          wcnt <= wcnt + WCW'(1);
          // request fields are registered here so HgStrt follows the last word by one cycle
          if (blk_full || last_word) begin
            state <= FIRE;
            bus.word_rdy <= 1'b0;
            bus.hg_strt <= 1'b1;
            bus.hg_bl <= last_blk ? 32'(len - 11'({blk, 6'd0})) : 32'd64;
            bus.hg_cs <= blk == '0;
            bus.hg_ce <= last_blk;
            bus.hg_root <= last_blk;
            bus.hg_h <= blk == '0 ? IV : cv;
          end
        end
        FIRE: state <= WAIT;
        WAIT: if (bus.hg_vld) begin
          cv <= bus.hg_res;
          if (bus.hg_ce) begin
            state <= DONE;
            bus.dig <= bus.hg_res;
            bus.dig_vld <= 1'b1;
          end else begin
            state <= LOAD;
            blk <= blk + BCW'(1);
            msg <= '0;
            bus.word_rdy <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
